rvfi_trace_fifo: RTL and testbench

RVFI_TRACE_FIFO -- requirements
Module: rvfi_trace_fifo

---
 rtl/rvfi_trace_fifo.sv | 135 +++++++++++++
 tb/tb_rvfi_trace_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_fifo.sv
// Retirement trace FIFO: stamps RVFI-style records with an order number and queues them for a consumer.
// Optional macro RVFI_TRACE_STALL_EN drives stall_o while the queue is full.
module rvfi_trace_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ret_valid,
   input  logic [31:0]                ret_pc,
   input  logic [31:0]                ret_nxt_pc,
   input  logic [31:0]                ret_insn,
   input  logic                       ret_trap,
   input  logic                       ret_intr,
   input  logic [4:0]                 ret_rd,
   input  logic [31:0]                ret_rd_wdata,
   input  logic [31:0]                ret_mem_addr,
   input  logic [3:0]                 ret_mem_rmask,
   input  logic [3:0]                 ret_mem_wmask,
   input  logic [31:0]                ret_mem_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [238:0]               out_pkt,
   output logic                       stall_o,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [31:0]    order_q, order_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]  level_q, level_d;
   logic [15:0]    drop_cnt_q, drop_cnt_d;
   logic [238:0]   mem_q [DEPTH];

   logic           pop_s, push_s, drop_s, full_s;
   logic [31:0]    rd_wdata_s, mem_data_s;
   logic [3:0]     rmask_s, wmask_s;
   logic [238:0]   wr_pkt_s;

   // Handshake decode, record sanitising and next-state computation.
   always_comb begin
      full_s = (level_q == FULL_LVL);
      pop_s  = out_valid && out_ready;
      push_s = ret_valid && (!full_s || pop_s);
      drop_s = ret_valid && full_s && !pop_s;

      // Trapped instructions carry no architectural writeback or memory effect.
      if (ret_trap || (ret_rd == 5'd0)) begin
         rd_wdata_s = 32'd0;
      end else begin
         rd_wdata_s = ret_rd_wdata;
      end
      if (ret_trap) begin
         rmask_s    = 4'd0;
         wmask_s    = 4'd0;
         mem_data_s = 32'd0;
      end else begin
         rmask_s    = ret_mem_rmask;
         wmask_s    = ret_mem_wmask;
         mem_data_s = ret_mem_data;
      end
      wr_pkt_s = {order_q, ret_pc, ret_nxt_pc, ret_insn, ret_trap, ret_intr, ret_rd,
                  rd_wdata_s, ret_mem_addr, rmask_s, wmask_s, mem_data_s};

      if (ret_valid && !ret_trap && !ret_intr) begin
         order_d = order_q + 32'd1;
      end else begin
         order_d = order_q;
      end

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Control state with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         order_q    <= 32'd0;
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         level_q    <= {LW{1'b0}};
         drop_cnt_q <= 16'd0;
      end else begin
         order_q    <= order_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Record storage is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wr_pkt_s;
      end
   end

   assign out_valid = (level_q != {LW{1'b0}});
   assign out_pkt   = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign drop_cnt  = drop_cnt_q;

`ifdef RVFI_TRACE_STALL_EN
   assign stall_o = full_s;
`else
   assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Directed testbench for rvfi_trace_fifo (DEPTH=8) with hand-computed expectations.
module tb_rvfi_trace_fifo;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ret_valid;
   logic [31:0]  ret_pc, ret_nxt_pc, ret_insn, ret_rd_wdata, ret_mem_addr, ret_mem_data;
   logic         ret_trap, ret_intr;
   logic [4:0]   ret_rd;
   logic [3:0]   ret_mem_rmask, ret_mem_wmask;
   logic         out_valid, out_ready, stall_o;
   logic [238:0] out_pkt;
   logic [3:0]   level;
   logic [15:0]  drop_cnt;

   int errors = 0;
   int checks = 0;
   logic exp_full_stall;

   rvfi_trace_fifo #(.DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
      .ret_nxt_pc(ret_nxt_pc), .ret_insn(ret_insn), .ret_trap(ret_trap),
      .ret_intr(ret_intr), .ret_rd(ret_rd), .ret_rd_wdata(ret_rd_wdata),
      .ret_mem_addr(ret_mem_addr), .ret_mem_rmask(ret_mem_rmask),
      .ret_mem_wmask(ret_mem_wmask), .ret_mem_data(ret_mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
      .stall_o(stall_o), .level(level), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [238:0] obs, input logic [238:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rec(input logic v, input logic [31:0] pc, input logic [31:0] nxt,
                      input logic [31:0] insn, input logic tr, input logic it,
                      input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] addr,
                      input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] md);
      ret_valid = v;  ret_pc = pc;  ret_nxt_pc = nxt;  ret_insn = insn;
      ret_trap = tr;  ret_intr = it;  ret_rd = rd;  ret_rd_wdata = wd;
      ret_mem_addr = addr;  ret_mem_rmask = rm;  ret_mem_wmask = wm;  ret_mem_data = md;
   endtask

   function automatic logic [238:0] pk(input logic [31:0] ord, input logic [31:0] pc,
                                       input logic [31:0] nxt, input logic [31:0] insn,
                                       input logic tr, input logic it, input logic [4:0] rd,
                                       input logic [31:0] wd, input logic [31:0] addr,
                                       input logic [3:0] rm, input logic [3:0] wm,
                                       input logic [31:0] md);
      return {ord, pc, nxt, insn, tr, it, rd, wd, addr, rm, wm, md};
   endfunction

   initial begin
`ifdef RVFI_TRACE_STALL_EN
      exp_full_stall = 1'b1;
`else
      exp_full_stall = 1'b0;
`endif
      rst_n = 1'b0;
      out_ready = 1'b0;
      rec(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0);
      #2;
      chk("rst_out_valid", 239'(out_valid), 239'(1'b0));
      chk("rst_level", 239'(level), 239'(4'd0));
      chk("rst_drop_cnt", 239'(drop_cnt), 239'(16'd0));
      chk("rst_stall", 239'(stall_o), 239'(1'b0));
      tick();
      tick();
      rst_n = 1'b1;

      // First record: visible only after the clock edge.
      rec(1'b1, 32'h100, 32'h104, 32'h00500093, 1'b0, 1'b0, 5'd1, 32'd5, 32'd0, 4'd0, 4'd0, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("no_bypass", 239'(out_valid), 239'(1'b0));
      tick();
      chk("a_valid", 239'(out_valid), 239'(1'b1));
      chk("a_level", 239'(level), 239'(4'd1));
      chk("a_pkt", out_pkt, pk(32'd0, 32'h100, 32'h104, 32'h00500093, 1'b0, 1'b0, 5'd1, 32'd5, 32'd0, 4'd0, 4'd0, 32'd0));

      rec(1'b1, 32'h104, 32'h108, 32'h00A00113, 1'b0, 1'b0, 5'd2, 32'd10, 32'd0, 4'd0, 4'd0, 32'd0);
      tick();
      chk("b_level", 239'(level), 239'(4'd1));
      chk("b_pkt", out_pkt, pk(32'd1, 32'h104, 32'h108, 32'h00A00113, 1'b0, 1'b0, 5'd2, 32'd10, 32'd0, 4'd0, 4'd0, 32'd0));

      // Trap record: writeback and memory fields cleared.
      rec(1'b1, 32'h108, 32'h80, 32'h00302023, 1'b1, 1'b0, 5'd3, 32'hAA, 32'h200, 4'd0, 4'hF, 32'h1234);
      tick();
      chk("c_trap_pkt", out_pkt, pk(32'd2, 32'h108, 32'h80, 32'h00302023, 1'b1, 1'b0, 5'd3, 32'd0, 32'h200, 4'd0, 4'd0, 32'd0));

      rec(1'b1, 32'h80, 32'h84, 32'h30002003, 1'b0, 1'b0, 5'd0, 32'h55, 32'h300, 4'hF, 4'd0, 32'hDEAD);
      tick();
      chk("d_after_trap_pkt", out_pkt, pk(32'd2, 32'h80, 32'h84, 32'h30002003, 1'b0, 1'b0, 5'd0, 32'd0, 32'h300, 4'hF, 4'd0, 32'hDEAD));

      rec(1'b1, 32'h84, 32'h40, 32'h00700213, 1'b0, 1'b1, 5'd4, 32'd7, 32'd0, 4'd0, 4'd0, 32'd0);
      tick();
      chk("e_intr_pkt", out_pkt, pk(32'd3, 32'h84, 32'h40, 32'h00700213, 1'b0, 1'b1, 5'd4, 32'd7, 32'd0, 4'd0, 4'd0, 32'd0));

      rec(1'b1, 32'h40, 32'h44, 32'h00900293, 1'b0, 1'b0, 5'd5, 32'd9, 32'd0, 4'd0, 4'd0, 32'd0);
      tick();
      chk("f_after_intr_order", 239'(out_pkt[238:207]), 239'(32'd3));

      rec(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0);
      tick();
      chk("drain_valid", 239'(out_valid), 239'(1'b0));
      chk("drain_level", 239'(level), 239'(4'd0));

      // Fill past capacity with the consumer stalled.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rec(1'b1, 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 5'd1, 32'(i), 32'd0, 4'd0, 4'd0, 32'd0);
         tick();
      end
      chk("full_level", 239'(level), 239'(4'd8));
      chk("full_drop_cnt", 239'(drop_cnt), 239'(16'd2));
      chk("full_stall", 239'(stall_o), 239'(exp_full_stall));
      chk("full_head_order", 239'(out_pkt[238:207]), 239'(32'd0));
      chk("full_head_pc", 239'(out_pkt[206:175]), 239'(32'h1000));

      // Push and pop together while full.
      rec(1'b1, 32'hBEEF0, 32'hBEEF4, 32'h00000013, 1'b0, 1'b0, 5'd1, 32'h77, 32'd0, 4'd0, 4'd0, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("pp_level", 239'(level), 239'(4'd8));
      chk("pp_drop_cnt", 239'(drop_cnt), 239'(16'd2));
      chk("pp_stall", 239'(stall_o), 239'(exp_full_stall));

      rec(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_order_%0d", i), 239'(out_pkt[238:207]), 239'((i < 7) ? 32'(i + 1) : 32'd10));
         chk($sformatf("drain_pc_%0d", i), 239'(out_pkt[206:175]), 239'((i < 7) ? 32'h1000 + 32'(4 * (i + 1)) : 32'hBEEF0));
         tick();
         chk($sformatf("drain_level_%0d", i), 239'(level), 239'(4'(7 - i)));
         chk($sformatf("drain_stall_%0d", i), 239'(stall_o), 239'(1'b0));
      end
      chk("empty_valid", 239'(out_valid), 239'(1'b0));

      // Asynchronous reset with records queued.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rec(1'b1, 32'h2000 + 32'(4 * i), 32'h2004 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 5'd2, 32'(i), 32'd0, 4'd0, 4'd0, 32'd0);
         tick();
      end
      chk("pre_rst_level", 239'(level), 239'(4'd5));
      chk("pre_rst_drop_cnt", 239'(drop_cnt), 239'(16'd2));
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 239'(out_valid), 239'(1'b0));
      chk("async_rst_level", 239'(level), 239'(4'd0));
      chk("async_rst_drop_cnt", 239'(drop_cnt), 239'(16'd0));
      #2;
      rst_n = 1'b1;
      rec(1'b1, 32'h500, 32'h504, 32'h00000013, 1'b0, 1'b0, 5'd6, 32'h66, 32'd0, 4'd0, 4'd0, 32'd0);
      tick();
      chk("post_rst_level", 239'(level), 239'(4'd1));
      chk("post_rst_order", 239'(out_pkt[238:207]), 239'(32'd0));
      chk("post_rst_pc", 239'(out_pkt[206:175]), 239'(32'h500));
      rec(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
